// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit accumulator CPU: opcode encoding, sequencer states
// and default datapath widths.
package cpu_pkg;

    localparam int DEF_WORD_W = 8;
    localparam int DEF_OP_W   = 3;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_BNE   = 3'b100,
        OP_BEQ   = 3'b101,
        OP_JMP   = 3'b110,
        OP_HALT  = 3'b111
    } opcode_t;

    // S_RESET is the idle state held during reset; the first edge after release enters S_FETCH_A.
    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH_A = 4'd1,
        S_FETCH_R = 4'd2,
        S_FETCH_I = 4'd3,
        S_DECODE  = 4'd4,
        S_RD      = 4'd5,
        S_EXE     = 4'd6,
        S_ST_M    = 4'd7,
        S_ST_W    = 4'd8,
        S_BR      = 4'd9,
        S_HALT    = 4'd10
    } state_t;

endpackage

// File: rtl/sequencer.sv
// Fetch/execute control FSM for the accumulator CPU. Pure Moore machine: outputs depend
// only on the state register and the opcode/zero flag captured when leaving DECODE.
module sequencer
    import cpu_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int OP_W   = DEF_OP_W
) (
    input  logic            clock,
    input  logic            n_reset,
    input  logic [OP_W-1:0] op,
    input  logic            z_flag,
    output logic            ACC_bus,
    output logic            load_ACC,
    output logic            PC_bus,
    output logic            load_PC,
    output logic            INC_PC,
    output logic            load_IR,
    output logic            Addr_bus,
    output logic            load_MAR,
    output logic            MDR_bus,
    output logic            load_MDR,
    output logic            CS,
    output logic            R_NW,
    output logic            ALU_ACC,
    output logic            ALU_add,
    output logic            ALU_sub,
    output logic            halted
);

    if (OP_W != 3 || WORD_W <= OP_W) begin : g_badParam
        $error("sequencer: decode table needs OP_W == 3 and WORD_W > OP_W");
    end

    state_t  r_state;
    state_t  w_nextState;
    opcode_t r_op;
    logic    r_zFlag;
    opcode_t w_opNow;

    assign w_opNow = opcode_t'(op);

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= S_RESET;
            r_op    <= OP_LOAD;
            r_zFlag <= 1'b0;
        end else begin
            r_state <= w_nextState;
            // Opcode and zero flag are latched once, on the edge leaving DECODE.
            if (r_state == S_DECODE) begin
                r_op    <= w_opNow;
                r_zFlag <= z_flag;
            end
        end
    end

    always_comb begin
        w_nextState = S_FETCH_A;
        ACC_bus  = 1'b0;
        load_ACC = 1'b0;
        PC_bus   = 1'b0;
        load_PC  = 1'b0;
        INC_PC   = 1'b0;
        load_IR  = 1'b0;
        Addr_bus = 1'b0;
        load_MAR = 1'b0;
        MDR_bus  = 1'b0;
        load_MDR = 1'b0;
        CS       = 1'b0;
        R_NW     = 1'b1;
        ALU_ACC  = 1'b0;
        ALU_add  = 1'b0;
        ALU_sub  = 1'b0;
        halted   = 1'b0;
        case (r_state)
            S_RESET: w_nextState = S_FETCH_A;
            S_FETCH_A: begin
                PC_bus      = 1'b1;
                load_MAR    = 1'b1;
                INC_PC      = 1'b1;
                w_nextState = S_FETCH_R;
            end
            S_FETCH_R: begin
                CS          = 1'b1;
                w_nextState = S_FETCH_I;
            end
            S_FETCH_I: begin
                MDR_bus     = 1'b1;
                load_IR     = 1'b1;
                w_nextState = S_DECODE;
            end
            // The operand address goes to MAR for every opcode; for branches and HALT the load is unused.
            S_DECODE: begin
                Addr_bus = 1'b1;
                load_MAR = 1'b1;
                case (w_opNow)
                    OP_LOAD, OP_ADD, OP_SUB:  w_nextState = S_RD;
                    OP_STORE:                 w_nextState = S_ST_M;
                    OP_BNE, OP_BEQ, OP_JMP:   w_nextState = S_BR;
                    default:                  w_nextState = S_HALT;
                endcase
            end
            S_RD: begin
                CS          = 1'b1;
                w_nextState = S_EXE;
            end
            S_EXE: begin
                MDR_bus  = 1'b1;
                load_ACC = 1'b1;
                case (r_op)
                    OP_ADD:  ALU_add = 1'b1;
                    OP_SUB:  ALU_sub = 1'b1;
                    default: ALU_ACC = 1'b1;
                endcase
            end
            S_ST_M: begin
                ACC_bus     = 1'b1;
                load_MDR    = 1'b1;
                w_nextState = S_ST_W;
            end
            S_ST_W: begin
                CS   = 1'b1;
                R_NW = 1'b0;
            end
            S_BR: begin
                Addr_bus = 1'b1;
                case (r_op)
                    OP_BNE:  load_PC = !r_zFlag;
                    OP_BEQ:  load_PC = r_zFlag;
                    default: load_PC = 1'b1;
                endcase
            end
            S_HALT: begin
                halted      = 1'b1;
                w_nextState = S_HALT;
            end
            default: w_nextState = S_FETCH_A;
        endcase
    end

    // Sysbus and memory-stage exclusivity, checked in every state outside reset.
    assert property (@(posedge clock) disable iff (!n_reset)
        $onehot0({ACC_bus, PC_bus, Addr_bus, MDR_bus}));
    assert property (@(posedge clock) disable iff (!n_reset)
        $onehot0({load_MAR, load_MDR, CS}));
    assert property (@(posedge clock) disable iff (!n_reset)
        (ALU_ACC || ALU_add || ALU_sub) |-> (load_ACC && $onehot({ALU_ACC, ALU_add, ALU_sub})));

endmodule

// File: tb/tb_sequencer.sv
// Self-checking bench for the sequencer: directed instruction runs, then random
// instructions with injected asynchronous resets, against a per-cycle table model.
module tb_sequencer;

    localparam logic [15:0] M_ACC_BUS  = 16'h8000;
    localparam logic [15:0] M_LOAD_ACC = 16'h4000;
    localparam logic [15:0] M_PC_BUS   = 16'h2000;
    localparam logic [15:0] M_LOAD_PC  = 16'h1000;
    localparam logic [15:0] M_INC_PC   = 16'h0800;
    localparam logic [15:0] M_LOAD_IR  = 16'h0400;
    localparam logic [15:0] M_ADDR_BUS = 16'h0200;
    localparam logic [15:0] M_LOAD_MAR = 16'h0100;
    localparam logic [15:0] M_MDR_BUS  = 16'h0080;
    localparam logic [15:0] M_LOAD_MDR = 16'h0040;
    localparam logic [15:0] M_CS       = 16'h0020;
    localparam logic [15:0] M_R_NW     = 16'h0010;
    localparam logic [15:0] M_ALU_ACC  = 16'h0008;
    localparam logic [15:0] M_ALU_ADD  = 16'h0004;
    localparam logic [15:0] M_ALU_SUB  = 16'h0002;
    localparam logic [15:0] M_HALTED   = 16'h0001;
    localparam logic [15:0] IDLE_VEC   = M_R_NW;

    logic       clock = 1'b0;
    logic       n_reset = 1'b0;
    logic [2:0] op = 3'b000;
    logic       z_flag = 1'b0;
    logic ACC_bus, load_ACC, PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR;
    logic MDR_bus, load_MDR, CS, R_NW, ALU_ACC, ALU_add, ALU_sub, halted;
    logic [15:0] outs;

    int checkCount = 0;
    int errorCount = 0;
    int cycleCount = 0;

    sequencer dut (
        .clock(clock), .n_reset(n_reset), .op(op), .z_flag(z_flag),
        .ACC_bus(ACC_bus), .load_ACC(load_ACC), .PC_bus(PC_bus), .load_PC(load_PC),
        .INC_PC(INC_PC), .load_IR(load_IR), .Addr_bus(Addr_bus), .load_MAR(load_MAR),
        .MDR_bus(MDR_bus), .load_MDR(load_MDR), .CS(CS), .R_NW(R_NW),
        .ALU_ACC(ALU_ACC), .ALU_add(ALU_add), .ALU_sub(ALU_sub), .halted(halted)
    );

    assign outs = {ACC_bus, load_ACC, PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR,
                   MDR_bus, load_MDR, CS, R_NW, ALU_ACC, ALU_add, ALU_sub, halted};

    always #5 clock = ~clock;

    always @(posedge clock) cycleCount++;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic bit isMemOp(input logic [2:0] o);
        return (o == 3'd0 || o == 3'd1 || o == 3'd2 || o == 3'd3);
    endfunction

    // Instruction length in cycles from FETCH_A up to the next FETCH_A.
    function automatic int instrLen(input logic [2:0] o, input int haltCycles);
        if (o == 3'd7) return 4 + haltCycles;
        return isMemOp(o) ? 6 : 5;
    endfunction

    // Expected control word for cycle 'step' (0 = FETCH_A) of an instruction.
    function automatic logic [15:0] expectedAt(input int step, input logic [2:0] o, input logic z);
        logic taken;
        taken = (o == 3'd6) || (o == 3'd4 && !z) || (o == 3'd5 && z);
        if (step == 0) return M_PC_BUS | M_LOAD_MAR | M_INC_PC | M_R_NW;
        if (step == 1) return M_CS | M_R_NW;
        if (step == 2) return M_MDR_BUS | M_LOAD_IR | M_R_NW;
        if (step == 3) return M_ADDR_BUS | M_LOAD_MAR | M_R_NW;
        if (o == 3'd7) return M_R_NW | M_HALTED;
        if (step == 4) begin
            if (o == 3'd1) return M_ACC_BUS | M_LOAD_MDR | M_R_NW;
            if (isMemOp(o)) return M_CS | M_R_NW;
            return M_ADDR_BUS | M_R_NW | (taken ? M_LOAD_PC : 16'h0000);
        end
        if (o == 3'd1) return M_CS;
        return M_MDR_BUS | M_LOAD_ACC | M_R_NW |
               (o == 3'd2 ? M_ALU_ADD : (o == 3'd3 ? M_ALU_SUB : M_ALU_ACC));
    endfunction

    // Holds reset for 'cycles' edges, checking idle outputs, then releases; returns in FETCH_A.
    task automatic doReset(input int cycles);
        n_reset = 1'b0;
        #1;
        checkOutput("resetAssert", outs, IDLE_VEC);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            #1;
            checkOutput("resetHold", outs, IDLE_VEC);
        end
        #2;
        n_reset = 1'b1;
        #1;
        checkOutput("resetRelease", outs, IDLE_VEC);
        @(posedge clock);
        #1;
    endtask

    // Runs one instruction starting in FETCH_A; abortStep >= 0 injects a reset in that cycle.
    task automatic applyStimulus(input logic [2:0] opIn, input logic zIn,
                                 input int abortStep, input int haltCycles);
        int len;
        logic [15:0] care;
        len    = instrLen(opIn, haltCycles);
        op     = opIn;
        z_flag = zIn;
        for (int step = 0; step < len; step++) begin
            if (step > 0) begin
                @(posedge clock);
                #1;
            end
            if (opIn == 3'd7 && step >= 4) op = 3'($urandom);
            care = (step == 3 && !isMemOp(opIn)) ? ~(M_ADDR_BUS | M_LOAD_MAR) : 16'hFFFF;
            checkOutput($sformatf("op%0d_z%0d_s%0d", opIn, zIn, step),
                        outs & care, expectedAt(step, opIn, zIn) & care);
            if (step == abortStep) begin
                #2;
                doReset(1 + int'($urandom_range(2)));
                return;
            end
        end
        if (opIn == 3'd7) doReset(1);
        else begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        logic [2:0] rOp;
        int         abortAt;
        $display("[TB] sequencer bench start");
        #2;
        checkOutput("resetInitial", outs, IDLE_VEC);
        doReset(3);

        for (int o = 0; o < 7; o++) begin
            applyStimulus(3'(o), 1'b0, -1, 0);
            applyStimulus(3'(o), 1'b1, -1, 0);
        end
        applyStimulus(3'd7, 1'b0, -1, 20);
        applyStimulus(3'd1, 1'b1, 5, 0);
        applyStimulus(3'd0, 1'b0, -1, 0);

        while (cycleCount < 10500) begin
            rOp     = ($urandom_range(15) == 0) ? 3'd7 : 3'($urandom_range(6));
            abortAt = ($urandom_range(9) == 0) ? int'($urandom_range(5)) : -1;
            applyStimulus(rOp, 1'($urandom), abortAt, 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
